sdram_burst_model: RTL

- Parametrised behavioural SDRAM device model. It is the next-generation replacement for the single-word bank model used in the controller testbench.
- Adds the following over the single-word model:
  - per-bank open-row tracking;
  - PRECHARGE and AUTO-REFRESH commands;
  - programmable CAS latency and burst length with wrapped column sequencing;
  - byte write masks;
  - illegal-command flagging.
- Sits on the SDRAM pins of the controller under test and serves as the scoreboard-visible memory image.

---
 rtl/sdram_burst_model.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/sdram_burst_model.sv
// Behavioural SDRAM device: per-bank open rows, refresh, wrapped bursts with byte
// masks, a CAS-latency read pipeline and illegal-command flagging.
//
// burst generator states
//   state    | meaning
//   IDLE     | no burst in flight; beat 0 of a new burst is issued on its command edge
//   RD_BURST | issuing read requests for beats 1..BURST_LEN-1
//   WR_BURST | writing beats 1..BURST_LEN-1 from the write data pins
module sdram_burst_model #(
    parameter int DATA_W    = 32,
    parameter int BANK_BITS = 2,
    parameter int ROW_BITS  = 10,
    parameter int COL_BITS  = 8,
    parameter int CAS_LAT   = 2,
    parameter int BURST_LEN = 4
) (
    input  logic                    in_CLK,
    input  logic                    in_RST,
    input  logic                    in_CS,
    input  logic                    in_RAS,
    input  logic                    in_CAS,
    input  logic                    in_write_en,
    input  logic [BANK_BITS-1:0]    in_bank_select,
    input  logic [ROW_BITS-1:0]     in_sdram_addr,
    input  logic [DATA_W-1:0]       in_sdram_write_data,
    input  logic [DATA_W/8-1:0]     in_dqm,
    output logic [DATA_W-1:0]       out_sdram_read_data,
    output logic                    out_read_valid,
    output logic                    out_cmd_err,
    output logic [2**BANK_BITS-1:0] out_bank_open,
    output logic [15:0]             out_refresh_count
);

    localparam int NUM_BANKS = 2**BANK_BITS;
    localparam int BYTES     = DATA_W/8;
    localparam int ADDR_W    = BANK_BITS + ROW_BITS + COL_BITS;
    localparam int CNT_W     = 4;
    localparam logic [COL_BITS-1:0] BURST_MASK = COL_BITS'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0]    LAST_BEAT  = CNT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST} burst_state_t;

    burst_state_t state, state_next;
    logic [CNT_W-1:0]    beat_cnt, cnt_next, beat_idx;
    logic [BANK_BITS-1:0] burst_bank, beat_bank;
    logic [ROW_BITS-1:0]  burst_row, beat_row;
    logic [COL_BITS-1:0]  burst_start, beat_start, beat_col;
    logic [ADDR_W-1:0]    beat_addr;
    logic                 beat_go, beat_rd;

    logic [ROW_BITS-1:0] open_row [NUM_BANKS];
    logic [DATA_W-1:0]   mem [2**ADDR_W];

    logic [CAS_LAT-1:0] pipe_v;
    logic [ADDR_W-1:0]  pipe_addr [CAS_LAT];

    logic [2:0] pins;
    logic live, cmd_act, cmd_rd, cmd_wr, cmd_pre, cmd_ref;
    logic target_open, any_open, start_burst, kill, err_next;

    always_comb begin
        pins        = {in_RAS, in_CAS, in_write_en};
        live        = !in_CS && !in_RST;
        cmd_act     = live && (pins == 3'b011);
        cmd_rd      = live && (pins == 3'b101);
        cmd_wr      = live && (pins == 3'b100);
        cmd_pre     = live && (pins == 3'b010);
        cmd_ref     = live && (pins == 3'b001);
        target_open = out_bank_open[in_bank_select];
        any_open    = |out_bank_open;
        start_burst = (cmd_rd || cmd_wr) && target_open;
        kill        = cmd_pre && (state != IDLE) && (burst_bank == in_bank_select);
        err_next    = (cmd_act && target_open) || ((cmd_rd || cmd_wr) && !target_open)
                      || (cmd_ref && any_open);
    end

    always_comb begin
        state_next = state;
        cnt_next   = beat_cnt;
        beat_go    = 1'b0;
        beat_rd    = 1'b0;
        beat_bank  = burst_bank;
        beat_row   = burst_row;
        beat_start = burst_start;
        beat_idx   = beat_cnt;
        if (start_burst) begin
            beat_go    = 1'b1;
            beat_rd    = cmd_rd;
            beat_bank  = in_bank_select;
            beat_row   = open_row[in_bank_select];
            beat_start = in_sdram_addr[COL_BITS-1:0];
            beat_idx   = '0;
            state_next = (BURST_LEN == 1) ? IDLE : (cmd_rd ? RD_BURST : WR_BURST);
            cnt_next   = CNT_W'(1);
        end else if (kill) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else if (state != IDLE) begin
            beat_go = 1'b1;
            beat_rd = (state == RD_BURST);
            if (beat_cnt == LAST_BEAT) begin
                state_next = IDLE;
                cnt_next   = '0;
            end else begin
                cnt_next = beat_cnt + CNT_W'(1);
            end
        end
        // Upper column bits stay fixed; only the low bits wrap within the burst.
        beat_col  = (beat_start & ~BURST_MASK)
                    | ((beat_start + COL_BITS'(beat_idx)) & BURST_MASK);
        beat_addr = {beat_bank, beat_row, beat_col};
    end

    always_ff @(posedge in_CLK or posedge in_RST) begin
        if (in_RST) begin
            state       <= IDLE;
            beat_cnt    <= '0;
            burst_bank  <= '0;
            burst_row   <= '0;
            burst_start <= '0;
        end else begin
            state    <= state_next;
            beat_cnt <= cnt_next;
            if (start_burst) begin
                burst_bank  <= in_bank_select;
                burst_row   <= open_row[in_bank_select];
                burst_start <= in_sdram_addr[COL_BITS-1:0];
            end
        end
    end

    always_ff @(posedge in_CLK or posedge in_RST) begin
        if (in_RST) begin
            out_bank_open     <= '0;
            out_refresh_count <= '0;
            out_cmd_err       <= 1'b0;
            for (int b = 0; b < NUM_BANKS; b++) open_row[b] <= '0;
        end else begin
            out_cmd_err <= err_next;
            if (cmd_act && !target_open) begin
                open_row[in_bank_select]      <= in_sdram_addr;
                out_bank_open[in_bank_select] <= 1'b1;
            end
            if (cmd_pre) out_bank_open[in_bank_select] <= 1'b0;
            if (cmd_ref && !any_open) out_refresh_count <= out_refresh_count + 16'd1;
        end
    end

    // The array itself survives reset; only the burst machinery is cleared.
    always_ff @(posedge in_CLK) begin
        if (beat_go && !beat_rd) begin
            for (int b = 0; b < BYTES; b++) begin
                if (!in_dqm[b]) mem[beat_addr][8*b +: 8] <= in_sdram_write_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge in_CLK or posedge in_RST) begin
        if (in_RST) begin
            pipe_v              <= '0;
            out_read_valid      <= 1'b0;
            out_sdram_read_data <= '0;
            for (int k = 0; k < CAS_LAT; k++) pipe_addr[k] <= '0;
        end else begin
            pipe_v[0]    <= beat_go && beat_rd;
            pipe_addr[0] <= beat_addr;
            for (int k = 1; k < CAS_LAT; k++) begin
                pipe_v[k]    <= pipe_v[k-1];
                pipe_addr[k] <= pipe_addr[k-1];
            end
            out_read_valid <= pipe_v[CAS_LAT-1];
            if (pipe_v[CAS_LAT-1]) out_sdram_read_data <= mem[pipe_addr[CAS_LAT-1]];
        end
    end

endmodule
